ddr_arbiter: RTL

DDR_ARBITER -- requirements
Module: ddr_arbiter

---
 rtl/ddr_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares one DDR command port between two cache requesters.
//
// Each requester owns a read slot and a write slot. That gives four slots:
// 0 = c0_rd, 1 = c0_wr, 2 = c1_rd, 3 = c1_wr. The DDR side has at most one
// transaction outstanding. Pending slots are granted round-robin.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   cN_rd_addr / cN_rd_en     read request (en is a one-cycle pulse)
//   cN_rd_fin / cN_rd_data    read completion pulse and returned line
//   cN_wr_addr/_data/_en      write request (en is a one-cycle pulse)
//   cN_wr_fin                 write completion pulse
//   cN_ovf                    sticky: a request was dropped, slot occupied
//   arb2DDR_rd_*              DDR read command (en one-cycle pulse)
//   DDR2arb_rd_fin/_data      DDR read completion and line
//   arb2DDR_wr_*              DDR write command (en one-cycle pulse)
//   DDR2arb_wr_fin            DDR write completion
//   busy                      a DDR transaction is outstanding
module ddr_arbiter #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic [ADDR_W-1:0] c0_rd_addr,
    input  logic              c0_rd_en,
    output logic              c0_rd_fin,
    output logic [LINE_W-1:0] c0_rd_data,
    input  logic [ADDR_W-1:0] c0_wr_addr,
    input  logic [LINE_W-1:0] c0_wr_data,
    input  logic              c0_wr_en,
    output logic              c0_wr_fin,
    output logic              c0_ovf,

    input  logic [ADDR_W-1:0] c1_rd_addr,
    input  logic              c1_rd_en,
    output logic              c1_rd_fin,
    output logic [LINE_W-1:0] c1_rd_data,
    input  logic [ADDR_W-1:0] c1_wr_addr,
    input  logic [LINE_W-1:0] c1_wr_data,
    input  logic              c1_wr_en,
    output logic              c1_wr_fin,
    output logic              c1_ovf,

    output logic [ADDR_W-1:0] arb2DDR_rd_addr,
    output logic              arb2DDR_rd_en,
    input  logic              DDR2arb_rd_fin,
    input  logic [LINE_W-1:0] DDR2arb_rd_data,

    output logic [ADDR_W-1:0] arb2DDR_wr_addr,
    output logic [LINE_W-1:0] arb2DDR_wr_data,
    output logic              arb2DDR_wr_en,
    input  logic              DDR2arb_wr_fin,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } state_t;

    state_t            state;

    // Slot storage. Write data only exists for the two write slots.
    logic [3:0]        pend;
    logic [ADDR_W-1:0] slot_addr [4];
    logic [LINE_W-1:0] slot_data [2];

    logic [1:0]        last;       // last granted slot
    logic [1:0]        cur;        // slot owning the outstanding transaction

    logic [3:0]        req;
    logic [ADDR_W-1:0] req_addr [4];
    logic [3:0]        done;
    logic [3:0]        drop;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;

    // Gather requester inputs into slot order.
    always_comb begin
        req         = {c1_wr_en, c1_rd_en, c0_wr_en, c0_rd_en};
        req_addr[0] = c0_rd_addr;
        req_addr[1] = c0_wr_addr;
        req_addr[2] = c1_rd_addr;
        req_addr[3] = c1_wr_addr;
    end

    // A slot completes only on the fin that matches the current wait state.
    // A new en for a pending slot is dropped unless that slot completes
    // on the same edge.
    always_comb begin
        done = '0;
        if ((state == WAIT_RD && DDR2arb_rd_fin) ||
            (state == WAIT_WR && DDR2arb_wr_fin)) begin
            done[cur] = 1'b1;
        end
        drop = req & pend & ~done;
    end

    // Round-robin search: start one past the last grant, wrap mod 4.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last;
        cand    = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!gnt_vld && pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Slot capture, completion clear and overflow flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend   <= '0;
            c0_ovf <= 1'b0;
            c1_ovf <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_addr[i] <= '0;
            end
            slot_data[0] <= '0;
            slot_data[1] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !drop[i]) begin
                    pend[i]      <= 1'b1;
                    slot_addr[i] <= req_addr[i];
                end else if (done[i]) begin
                    pend[i]      <= 1'b0;
                end
            end
            if (c0_wr_en && !drop[1]) begin
                slot_data[0] <= c0_wr_data;
            end
            if (c1_wr_en && !drop[3]) begin
                slot_data[1] <= c1_wr_data;
            end
            if (|drop[1:0]) begin
                c0_ovf <= 1'b1;
            end
            if (|drop[3:2]) begin
                c1_ovf <= 1'b1;
            end
        end
    end

    // Grant / wait / complete FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            last            <= 2'd3;
            cur             <= 2'd0;
            busy            <= 1'b0;
            arb2DDR_rd_addr <= '0;
            arb2DDR_rd_en   <= 1'b0;
            arb2DDR_wr_addr <= '0;
            arb2DDR_wr_data <= '0;
            arb2DDR_wr_en   <= 1'b0;
            c0_rd_fin       <= 1'b0;
            c0_wr_fin       <= 1'b0;
            c1_rd_fin       <= 1'b0;
            c1_wr_fin       <= 1'b0;
            c0_rd_data      <= '0;
            c1_rd_data      <= '0;
        end else begin
            arb2DDR_rd_en <= 1'b0;
            arb2DDR_wr_en <= 1'b0;
            c0_rd_fin     <= 1'b0;
            c0_wr_fin     <= 1'b0;
            c1_rd_fin     <= 1'b0;
            c1_wr_fin     <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (gnt_vld) begin
                        last <= gnt_idx;
                        cur  <= gnt_idx;
                        busy <= 1'b1;
                        // Even slots are reads, odd slots are writes.
                        if (!gnt_idx[0]) begin
                            arb2DDR_rd_addr <= slot_addr[gnt_idx];
                            arb2DDR_rd_en   <= 1'b1;
                            state           <= WAIT_RD;
                        end else begin
                            arb2DDR_wr_addr <= slot_addr[gnt_idx];
                            arb2DDR_wr_data <= slot_data[gnt_idx[1]];
                            arb2DDR_wr_en   <= 1'b1;
                            state           <= WAIT_WR;
                        end
                    end
                end

                WAIT_RD: begin
                    if (DDR2arb_rd_fin) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (cur[1]) begin
                            c1_rd_data <= DDR2arb_rd_data;
                            c1_rd_fin  <= 1'b1;
                        end else begin
                            c0_rd_data <= DDR2arb_rd_data;
                            c0_rd_fin  <= 1'b1;
                        end
                    end
                end

                WAIT_WR: begin
                    if (DDR2arb_wr_fin) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (cur[1]) begin
                            c1_wr_fin <= 1'b1;
                        end else begin
                            c0_wr_fin <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
